hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the MIPS150 pipeline. It sits beside the decode stage and tracks the destination registers of up to DEPTH in-flight instructions from EX through WB in its own shift-register scoreboard. Each cycle it produces per-operand forwarding selects, load-use stalls and redirect flushes. It replaces the single-previous-instruction forwarding compare with depth-generic, load-latency-aware hazard detection.

## Interface
- DEPTH, 3: number of tracked stages after ID (entry 0 = EX … entry DEPTH-1 = WB); legal range 2..8.
- LOAD_LAT, 1: cycles after EX before load data can be forwarded; must satisfy 0 ≤ LOAD_LAT < DEPTH-1.
- REG_W, 5: register-specifier width.
- SEL_W, $clog2(DEPTH): forwarding-select width, derived.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_W  source specifiers.
- id_use_rs, id_use_rt  in  1  operand actually read.
- id_dest  in  REG_W  destination specifier (rd, rt or 31, already muxed).
- id_we  in  1  instruction writes id_dest.
- id_is_load  in  1  instruction is LB/LH/LW/LBU/LHU.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- fwd_sel_a, fwd_sel_b  out  SEL_W  0 = register file, k = result of entry k (when consumer is in EX).
- stall  out  1  hold PC and IF/ID, insert bubble into EX.
- flush  out  1  kill IF/ID contents.
- stall_cycles  out  32  saturating count of cycles with stall=1.

## Operation
- Scoreboard entry: {valid, dest, we, is_load}. It is a shift register advancing every cycle. Entry DEPTH-1 drops off; the RF is write-through, so WB results are visible to ID.
- Entry 0 load value:
  - if flush or stall: bubble (valid=0).
  - else: {id_valid, id_dest, id_we & (id_dest≠0), id_is_load}.
- Match per operand: entry k, k in 0..DEPTH-2, matches if valid & we & dest==src & use_src & src≠0. The youngest match (lowest k) wins.
- fwd_sel:
  - winning k gives sel = k+1.
  - no match gives 0.
  - sel is forced to 0 while stall or flush is asserted.
- Load-use hazard: winning entry is_load and k < LOAD_LAT. In that case stall=1 (requires id_valid).
  - With LOAD_LAT=1, a load in EX stalls a dependent instruction exactly one cycle.
  - A load at k ≥ LOAD_LAT forwards normally.
- flush = ex_redirect.
  - Simultaneous redirect and hazard: flush wins and stall=0, because the stalled instruction is being killed.
- stall_cycles increments on stall and saturates at 32'hFFFF_FFFF.
- All of fwd_sel/stall/flush are combinational from current scoreboard state and ID inputs. There are no combinational paths from outputs back to inputs.

## Timing
- Reset (asynchronous assert, synchronous release on the first clk edge after reset_n=1):
  - all entry valid bits are 0 and stall_cycles=0.
  - consequently fwd_sel=0, stall=0, flush=ex_redirect.
- Reset mid-stream discards all tracked producers. The first instruction after reset reads the RF.
- Zero-cycle decision latency: outputs are valid in the same cycle as the ID inputs and are captured into ID/EX at the next edge.
- A stalled ID instruction is re-evaluated every cycle. stall releases in the cycle the load reaches entry LOAD_LAT, and that cycle yields sel = LOAD_LAT+1.
- A producer leaves the scoreboard DEPTH cycles after entering EX.

## Structure
- Shared package hazard_pkg: scoreboard-entry struct, REG_W default, and the zero-register constant REG_ZERO.
- Sub-module hazard_match: one instance per source operand. It takes the entry vector and a source specifier, and returns the youngest-match index, hit and is_load.
- Top level holds the shift register, the stall/flush arbitration and the counter.

## Test plan
- ALU back-to-back: addu $3,$1,$2 then addu $4,$3,$3 (DEPTH=3) -> fwd_sel_a=fwd_sel_b=1, stall=0.
- Distance 2: producer writes $5, independent op, consumer reads $5 -> sel=2; at distance 3 -> sel=0 (RF write-through).
- Load-use with LOAD_LAT=1: lw $6 then addu $7,$6,$0 -> exactly one stall cycle, then fwd_sel_a=2, stall_cycles=1. With LOAD_LAT=0, no stall and sel=1.
- $0 and priority: writes to $0 never forwarded (sel=0). Two producers of $8 at k=0 and k=1 -> sel=1 (youngest).
- Redirect during load-use stall: ex_redirect=1 with pending hazard -> flush=1, stall=0, bubble in entry 0, stall_cycles unchanged.
- Reset mid-stream: pull reset_n low with valid entries -> next consumer of a prior dest gets sel=0, stall=0; stall_cycles returns to 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS150 hazard/forwarding scoreboard.
package hazard_pkg;

  // Default register-specifier width (32 architectural registers).
  localparam int HZ_REG_W  = 5;

  // Storage width for destination specifiers inside an entry. Wide enough
  // for any REG_W up to 8 so the entry struct can stay non-parameterised.
  localparam int HZ_DEST_W = 8;

  // $0 is hard-wired to zero and is never a forwarding source.
  localparam logic [HZ_DEST_W-1:0] REG_ZERO = '0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                 valid;
    logic [HZ_DEST_W-1:0] dest;
    logic                 we;
    logic                 is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer search for one source operand over the scoreboard.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NUM   = 2,
  parameter int REG_W = HZ_REG_W,
  parameter int SEL_W = 2
) (
  input  sb_entry_t [NUM-1:0] i_entries,
  input  logic [REG_W-1:0]    i_src,
  input  logic                i_use,
  output logic [SEL_W-1:0]    o_idx,
  output logic                o_hit,
  output logic                o_is_load
);

  logic [HZ_DEST_W-1:0] w_src;

  assign w_src = HZ_DEST_W'(i_src);

  // Scan oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    o_hit     = 1'b0;
    o_idx     = '0;
    o_is_load = 1'b0;
    if (i_use && (w_src != REG_ZERO)) begin
      for (int k = NUM - 1; k >= 0; k--) begin
        if (i_entries[k].valid && i_entries[k].we && (i_entries[k].dest == w_src)) begin
          o_hit     = 1'b1;
          o_idx     = SEL_W'(k);
          o_is_load = i_entries[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Depth-generic, load-latency-aware hazard and forwarding controller.
// Tracks in-flight destinations from EX onward and produces forwarding
// selects, load-use stalls and redirect flushes for the ID stage.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int REG_W    = HZ_REG_W,
  parameter int SEL_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             stall,
  output logic             flush,
  output logic [31:0]      stall_cycles
);

  // Only entries 0..DEPTH-2 can ever be a forwarding source. The WB slot is
  // not stored: the register file is write-through, so a producer in WB is
  // already visible to ID and simply drops off the end of the shift register.
  localparam int NUM = DEPTH - 1;

  sb_entry_t [NUM-1:0] r_sb;
  sb_entry_t           w_entry0;
  logic [31:0]         r_stall_cycles;

  logic [SEL_W-1:0] w_idx_a, w_idx_b;
  logic             w_hit_a, w_hit_b;
  logic             w_ld_a, w_ld_b;
  logic             w_hz_a, w_hz_b;
  logic             w_hazard;
  logic             w_kill;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  hazard_match #(.NUM(NUM), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_a (
    .i_entries (r_sb),
    .i_src     (id_rs),
    .i_use     (id_use_rs),
    .o_idx     (w_idx_a),
    .o_hit     (w_hit_a),
    .o_is_load (w_ld_a)
  );

  hazard_match #(.NUM(NUM), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_b (
    .i_entries (r_sb),
    .i_src     (id_rt),
    .i_use     (id_use_rt),
    .o_idx     (w_idx_b),
    .o_hit     (w_hit_b),
    .o_is_load (w_ld_b)
  );

  // A load younger than LOAD_LAT stages has no data to forward yet.
  assign w_hz_a   = w_hit_a & w_ld_a & (int'({1'b0, w_idx_a}) < LOAD_LAT);
  assign w_hz_b   = w_hit_b & w_ld_b & (int'({1'b0, w_idx_b}) < LOAD_LAT);
  assign w_hazard = id_valid & (w_hz_a | w_hz_b);

  // A redirect kills the ID instruction, so it overrides any pending stall.
  assign flush  = ex_redirect;
  assign stall  = w_hazard & ~ex_redirect;
  assign w_kill = stall | flush;

  assign fwd_sel_a = (w_hit_a && !w_kill) ? (w_idx_a + SEL_W'(1)) : '0;
  assign fwd_sel_b = (w_hit_b && !w_kill) ? (w_idx_b + SEL_W'(1)) : '0;

  assign stall_cycles = r_stall_cycles;

  // Build the entry entering EX: a bubble when ID is stalled or killed.
  always_comb begin
    w_entry0 = '0;
    if (!w_kill) begin
      w_entry0.valid   = id_valid;
      w_entry0.dest    = HZ_DEST_W'(id_dest);
      w_entry0.we      = id_we & (HZ_DEST_W'(id_dest) != REG_ZERO);
      w_entry0.is_load = id_is_load;
    end
  end

  // Advance the scoreboard every cycle; reset only clears the valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM; k++) begin
        r_sb[k].valid <= 1'b0;
      end
    end else begin
      r_sb[0] <= w_entry0;
      for (int k = 1; k < NUM; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (stall) begin
      r_stall_cycles <= sat_inc32(r_stall_cycles);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3). A LOAD_LAT=1 instance is
// the main device; a LOAD_LAT=0 instance shares the inputs and is compared
// only while both instances hold identical scoreboard contents.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_use_rs, id_use_rt, id_we, id_is_load;
  logic        ex_redirect;

  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        stall, flush;
  logic [31:0] stall_cycles;

  logic [1:0]  fwd_sel_a0, fwd_sel_b0;
  logic        stall0, flush0;
  logic [31:0] stall_cycles0;

  hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .REG_W(5)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall        (stall),
    .flush        (flush),
    .stall_cycles (stall_cycles)
  );

  hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(0), .REG_W(5)) u_dut0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .fwd_sel_a    (fwd_sel_a0),
    .fwd_sel_b    (fwd_sel_b0),
    .stall        (stall0),
    .flush        (flush0),
    .stall_cycles (stall_cycles0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     tag;
    int     sa;
    int     sb;
    int     st;
    int     fl;
    longint cnt;
    bit     c0;
    int     sa0;
    int     st0;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tag   = 0;

  task automatic chk(input int t, input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL c%0d %s actual=%0d required=%0d", t, nm, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a pending
  // expectation is checked at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, "sel_a", longint'(fwd_sel_a), longint'(e.sa));
      chk(e.tag, "sel_b", longint'(fwd_sel_b), longint'(e.sb));
      chk(e.tag, "stall", longint'(stall), longint'(e.st));
      chk(e.tag, "flush", longint'(flush), longint'(e.fl));
      chk(e.tag, "stall_cycles", longint'(stall_cycles), e.cnt);
      if (e.c0) begin
        chk(e.tag, "lat0_sel_a", longint'(fwd_sel_a0), longint'(e.sa0));
        chk(e.tag, "lat0_sel_b", longint'(fwd_sel_b0), longint'(e.sb));
        chk(e.tag, "lat0_stall", longint'(stall0), longint'(e.st0));
        chk(e.tag, "lat0_flush", longint'(flush0), longint'(e.fl));
        chk(e.tag, "lat0_stall_cycles", longint'(stall_cycles0), 64'd0);
      end
    end
  end

  task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int dest, input bit we, input bit ld, input bit redir);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_use_rs   = urs;
    id_rt       = 5'(rt);
    id_use_rt   = urt;
    id_dest     = 5'(dest);
    id_we       = we;
    id_is_load  = ld;
    ex_redirect = redir;
  endtask

  task automatic step(input int sa, input int sb, input int st, input int fl, input longint cnt,
                      input bit c0, input int sa0, input int st0);
    exp_t e;
    e.tag = tag; e.sa = sa; e.sb = sb; e.st = st; e.fl = fl; e.cnt = cnt;
    e.c0 = c0; e.sa0 = sa0; e.st0 = st0;
    q.push_back(e);
    tag++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d checks pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // In reset: nothing tracked, flush follows ex_redirect.
    drive(1, 3, 1, 3, 1, 3, 1, 0, 1); step(0, 0, 0, 1, 0, 1, 0, 0);
    drive(1, 3, 1, 3, 1, 3, 1, 0, 0); step(0, 0, 0, 0, 0, 1, 0, 0);
    reset_n = 1'b1;
    // ALU back-to-back: addu $3,$1,$2 ; addu $4,$3,$3
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0); step(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 3, 1, 3, 1, 4, 1, 0, 0); step(1, 1, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 1, 0, 0);
    // Distance 2 then 3 for $5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); step(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 0, 9, 1, 0, 0); step(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 5, 1, 0, 0, 10, 1, 0, 0); step(2, 0, 0, 0, 0, 1, 2, 0);
    drive(1, 9, 1, 5, 1, 0, 0, 0, 0); step(2, 0, 0, 0, 0, 1, 2, 0);
    // Load-use: lw $6 ; addu $7,$6,$0
    drive(1, 1, 1, 0, 0, 6, 1, 1, 0); step(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 6, 1, 0, 1, 7, 1, 0, 0); step(0, 0, 1, 0, 0, 1, 1, 0);
    drive(1, 6, 1, 0, 1, 7, 1, 0, 0); step(2, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 1, 0, 0, 0);
    // $0 writer, then two producers of $8, youngest wins
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 1, 8, 1, 0, 0); step(0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0); step(0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 8, 1, 8, 1, 11, 1, 0, 0); step(1, 1, 0, 0, 1, 0, 0, 0);
    // Operand not read is never forwarded
    drive(1, 11, 0, 11, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 1, 0, 0, 0);
    // Redirect during load-use: flush wins, bubble enters EX
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0); step(0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 12, 1, 0, 0, 12, 1, 0, 1); step(0, 0, 0, 1, 1, 0, 0, 0);
    drive(1, 12, 1, 0, 0, 0, 0, 0, 0); step(2, 0, 0, 0, 1, 0, 0, 0);
    // Reset mid-stream with live producers
    drive(1, 0, 0, 0, 0, 13, 1, 0, 0); step(0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 14, 1, 1, 0); step(0, 0, 0, 0, 1, 0, 0, 0);
    reset_n = 1'b0;
    drive(1, 14, 1, 13, 1, 15, 1, 0, 0); step(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(1, 14, 1, 13, 1, 15, 1, 0, 0); step(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 15, 1, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
